// File: rtl/xbar_pkg.sv
// xbar_pkg: shared defaults and index-width helper for the xbar_rr crossbar.
// Holds DEF_N_IN/DEF_N_OUT/DEF_WIDTH and idx_w() = max(1, clog2(n)).
package xbar_pkg;

  localparam int DEF_N_IN  = 3;
  localparam int DEF_N_OUT = 3;
  localparam int DEF_WIDTH = 48;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_rr_if.sv
// xbar_rr_if: flit ports of the crossbar (in_* valid/ready/data/dest/tail,
// out_* valid/ready/data/tail/src, dest_err); master = environment, slave = xbar.
interface xbar_rr_if
  import xbar_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int DW = idx_w(N_OUT);
  localparam int SW = idx_w(N_IN);

  logic [N_IN-1:0]        in_valid;
  logic [N_IN-1:0]        in_ready;
  logic [N_IN*WIDTH-1:0]  in_data;
  logic [N_IN*DW-1:0]     in_dest;
  logic [N_IN-1:0]        in_tail;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_tail;
  logic [N_OUT*SW-1:0]    out_src;
  logic                   dest_err;

  modport master (
    output in_valid, in_data, in_dest, in_tail, out_ready,
    input  in_ready, out_valid, out_data, out_tail, out_src,
    input  dest_err
  );

  modport slave (
    input  in_valid, in_data, in_dest, in_tail, out_ready,
    output in_ready, out_valid, out_data, out_tail, out_src,
    output dest_err
  );

endinterface

// File: rtl/xbar_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req at/after ptr.
// Ports: req, ptr in; grant (one-hot), grant_idx, any out.
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N  = DEF_N_IN,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int j;
    j = 0;
    grant = '0;
    grant_idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        grant[j] = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/xbar_rr.sv
// xbar_rr: registered N_IN x N_OUT crossbar, per-output round-robin, 1-entry
// output regs. Ports: clk, reset (async, active-low), bus (xbar_rr_if.slave).
// Optional packet locking: XBAR_PKT_LOCK_EN.
module xbar_rr
  import xbar_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic      clk,
  input logic      reset,
  xbar_rr_if.slave bus
);

  localparam int DW = idx_w(N_OUT);
  localparam int SW = idx_w(N_IN);

  logic [N_IN-1:0]        req [N_OUT];
  logic [N_IN-1:0]        arb_gnt [N_OUT];
  logic [SW-1:0]          arb_idx [N_OUT];
  logic [N_OUT-1:0]       arb_any;
  logic [N_IN-1:0]        illegal;
  logic [N_IN-1:0]        rdy;

  logic [N_OUT-1:0]       vld_q, vld_d;
  logic [N_OUT-1:0]       tail_q, tail_d;
  logic [N_OUT*WIDTH-1:0] data_q, data_d;
  logic [N_OUT*SW-1:0]    src_q, src_d;
  logic [SW-1:0]          ptr_q [N_OUT];
  logic [SW-1:0]          ptr_d [N_OUT];
  logic                   err_q, err_d;

`ifdef XBAR_PKT_LOCK_EN
  logic [N_OUT-1:0]       lock_q, lock_d;
  logic [SW-1:0]          lsrc_q [N_OUT];
  logic [SW-1:0]          lsrc_d [N_OUT];
`endif

  // Decode each input's destination into per-output request vectors.
  always_comb begin
    logic [DW-1:0] dst;
    dst = '0;
    illegal = '0;
    for (int o = 0; o < N_OUT; o++) req[o] = '0;
    for (int i = 0; i < N_IN; i++) begin
      dst = bus.in_dest[i*DW +: DW];
      if (bus.in_valid[i]) begin
        if (int'(dst) >= N_OUT) illegal[i] = 1'b1;
        for (int o = 0; o < N_OUT; o++)
          if (int'(dst) == o) req[o][i] = 1'b1;
      end
    end
`ifdef XBAR_PKT_LOCK_EN
    // A locked output only sees the packet owner.
    for (int o = 0; o < N_OUT; o++)
      if (lock_q[o]) req[o] = req[o] & (N_IN'(1) << lsrc_q[o]);
`endif
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_arb
    rr_arbiter #(.N(N_IN), .PW(SW)) u_arb (
      .req       (req[o]),
      .ptr       (ptr_q[o]),
      .grant     (arb_gnt[o]),
      .grant_idx (arb_idx[o]),
      .any       (arb_any[o])
    );
  end

  always_comb begin
    logic [SW-1:0] g;
    g = '0;
    // Illegal destinations are swallowed unconditionally.
    rdy = illegal;
    vld_d = vld_q;
    tail_d = tail_q;
    data_d = data_q;
    src_d = src_q;
    ptr_d = ptr_q;
    err_d = err_q | (|illegal);
`ifdef XBAR_PKT_LOCK_EN
    lock_d = lock_q;
    lsrc_d = lsrc_q;
`endif
    for (int o = 0; o < N_OUT; o++) begin
      if ((!vld_q[o] || bus.out_ready[o]) && arb_any[o]) begin
        g = arb_idx[o];
        rdy = rdy | arb_gnt[o];
        vld_d[o] = 1'b1;
        data_d[o*WIDTH +: WIDTH] = bus.in_data[int'(g)*WIDTH +: WIDTH];
        tail_d[o] = bus.in_tail[g];
        src_d[o*SW +: SW] = g;
        ptr_d[o] = (int'(g) == N_IN - 1) ? '0 : g + SW'(1);
`ifdef XBAR_PKT_LOCK_EN
        lock_d[o] = !bus.in_tail[g];
        lsrc_d[o] = g;
`endif
      end else if (bus.out_ready[o]) begin
        vld_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      tail_q <= '0;
      data_q <= '0;
      src_q <= '0;
      err_q <= 1'b0;
      for (int o = 0; o < N_OUT; o++) ptr_q[o] <= '0;
`ifdef XBAR_PKT_LOCK_EN
      lock_q <= '0;
      for (int o = 0; o < N_OUT; o++) lsrc_q[o] <= '0;
`endif
    end else begin
      vld_q <= vld_d;
      tail_q <= tail_d;
      data_q <= data_d;
      src_q <= src_d;
      err_q <= err_d;
      ptr_q <= ptr_d;
`ifdef XBAR_PKT_LOCK_EN
      lock_q <= lock_d;
      lsrc_q <= lsrc_d;
`endif
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_tail  = tail_q;
  assign bus.out_src   = src_q;
  assign bus.dest_err  = err_q;

endmodule

// File: tb/tb_xbar_rr.sv
// tb_xbar_rr: directed + randomized checks of xbar_rr against a queue-free
// behavioural model of round-robin outputs (honours XBAR_PKT_LOCK_EN).
module tb_xbar_rr;

  localparam int NI = 3;
  localparam int NO = 3;
  localparam int W  = 48;
  localparam int DW = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  xbar_rr_if #(.N_IN(NI), .N_OUT(NO), .WIDTH(W)) bus ();

  xbar_rr #(.N_IN(NI), .N_OUT(NO), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic          d_valid [NI];
  logic [W-1:0]  d_data  [NI];
  logic [DW-1:0] d_dest  [NI];
  logic          d_tail  [NI];
  logic [NO-1:0] d_ordy;

  bit            m_vld  [NO];
  logic [W-1:0]  m_data [NO];
  bit            m_tail [NO];
  int            m_src  [NO];
  int            m_ptr  [NO];
  bit            m_lock [NO];
  int            m_lsrc [NO];
  bit            m_err;
  int            win    [NO];
  logic [NI-1:0] exp_rdy;

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) begin
      d_valid[i] = 1'b0;
      d_data[i] = '0;
      d_dest[i] = '0;
      d_tail[i] = 1'b0;
    end
    d_ordy = '0;
  endtask

  task automatic apply();
    for (int i = 0; i < NI; i++) begin
      bus.in_valid[i] = d_valid[i];
      bus.in_data[i*W +: W] = d_data[i];
      bus.in_dest[i*DW +: DW] = d_dest[i];
      bus.in_tail[i] = d_tail[i];
    end
    bus.out_ready = d_ordy;
  endtask

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      m_vld[o] = 0;
      m_data[o] = '0;
      m_tail[o] = 0;
      m_src[o] = 0;
      m_ptr[o] = 0;
      m_lock[o] = 0;
      m_lsrc[o] = 0;
      win[o] = -1;
    end
    m_err = 0;
  endtask

  // Which input each output would take this cycle, and the resulting ready.
  task automatic model_eval();
    exp_rdy = '0;
    for (int o = 0; o < NO; o++) begin
      win[o] = -1;
      if (!m_vld[o] || d_ordy[o]) begin
        for (int k = 0; k < NI; k++) begin
          int i;
          i = (m_ptr[o] + k) % NI;
          if (win[o] < 0 && d_valid[i] && int'(d_dest[i]) == o &&
              (!m_lock[o] || m_lsrc[o] == i))
            win[o] = i;
        end
      end
      if (win[o] >= 0) exp_rdy[win[o]] = 1'b1;
    end
    for (int i = 0; i < NI; i++)
      if (d_valid[i] && int'(d_dest[i]) >= NO) exp_rdy[i] = 1'b1;
  endtask

  task automatic model_commit();
    for (int o = 0; o < NO; o++) begin
      if (win[o] >= 0) begin
        m_vld[o] = 1;
        m_data[o] = d_data[win[o]];
        m_tail[o] = d_tail[win[o]];
        m_src[o] = win[o];
        m_ptr[o] = (win[o] + 1) % NI;
`ifdef XBAR_PKT_LOCK_EN
        m_lock[o] = !d_tail[win[o]];
        m_lsrc[o] = win[o];
`endif
      end else if (d_ordy[o]) begin
        m_vld[o] = 0;
      end
    end
    for (int i = 0; i < NI; i++)
      if (d_valid[i] && int'(d_dest[i]) >= NO) m_err = 1;
  endtask

  task automatic settle();
    apply();
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    apply();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    apply();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 3'b000) begin
      errors++; $display("FAIL reset_valid: got %b exp 000", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h exp 0", bus.out_data);
    end
    checks++;
    if (bus.out_tail !== 3'b000 || bus.out_src !== '0) begin
      errors++;
      $display("FAIL reset_tail_src: got %b/%h exp 0", bus.out_tail, bus.out_src);
    end
    checks++;
    if (bus.dest_err !== 1'b0 || bus.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_err_rdy: got %b/%b exp 0", bus.dest_err, bus.in_ready);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    clear_inputs();
    d_valid[0] = 1; d_data[0] = 48'hAAAA; d_dest[0] = 2; d_tail[0] = 1;
    d_ordy = '1;
    settle();
    checks++;
    if (bus.in_ready !== 3'b001) begin
      errors++; $display("FAIL single_rdy: got %b exp 001", bus.in_ready);
    end
    advance();
    checks++;
    if (bus.out_valid !== 3'b100) begin
      errors++; $display("FAIL single_valid: got %b exp 100", bus.out_valid);
    end
    checks++;
    if (bus.out_data[2*W +: W] !== 48'hAAAA) begin
      errors++;
      $display("FAIL single_data: got %h exp aaaa", bus.out_data[2*W +: W]);
    end
    checks++;
    if (bus.out_src[2*SW +: SW] !== 2'd0 || bus.out_tail[2] !== 1'b1) begin
      errors++;
      $display("FAIL single_src: got %0d/%b exp 0/1",
               bus.out_src[2*SW +: SW], bus.out_tail[2]);
    end
    clear_inputs();
    d_ordy = '1;
    settle();
    advance();
    checks++;
    if (bus.out_valid !== 3'b000) begin
      errors++; $display("FAIL single_drain: got %b exp 000", bus.out_valid);
    end
  endtask

  task automatic test_contention();
    logic [NI-1:0] e;
    clear_inputs();
    for (int i = 0; i < NI; i++) begin
      d_valid[i] = 1; d_dest[i] = 1; d_tail[i] = 1;
      d_data[i] = 48'h100 + 48'(i);
    end
    d_ordy = '1;
    for (int k = 0; k < 6; k++) begin
      e = 3'b001 << (k % 3);
      settle();
      checks++;
      if (bus.in_ready !== e) begin
        errors++; $display("FAIL cont_rdy[%0d]: got %b exp %b", k, bus.in_ready, e);
      end
      advance();
      checks++;
      if (bus.out_src[1*SW +: SW] !== SW'(k % 3) || bus.out_valid[1] !== 1'b1) begin
        errors++;
        $display("FAIL cont_src[%0d]: got %0d exp %0d", k,
                 bus.out_src[1*SW +: SW], k % 3);
      end
    end
    clear_inputs();
    d_ordy = '1;
    settle();
    advance();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    d_valid[0] = 1; d_dest[0] = 0; d_tail[0] = 1; d_data[0] = 48'h0B0B_0001;
    d_ordy = '1;
    settle();
    advance();
    d_data[0] = 48'h0B0B_0002;
    d_ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if (bus.in_ready[0] !== 1'b0) begin
        errors++; $display("FAIL bp_rdy[%0d]: got %b exp 0", k, bus.in_ready[0]);
      end
      advance();
      checks++;
      if (bus.out_data[0 +: W] !== 48'h0B0B_0001 || bus.out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h exp 0b0b0001", k, bus.out_data[0 +: W]);
      end
    end
    d_ordy[0] = 1'b1;
    settle();
    checks++;
    if (bus.in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_release_rdy: got %b exp 1", bus.in_ready[0]);
    end
    advance();
    checks++;
    if (bus.out_data[0 +: W] !== 48'h0B0B_0002 || bus.out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_next: got %h/%b exp 0b0b0002/1",
               bus.out_data[0 +: W], bus.out_valid[0]);
    end
    clear_inputs();
    d_ordy = '1;
    settle();
    advance();
  endtask

  task automatic test_illegal();
    clear_inputs();
    d_valid[1] = 1; d_dest[1] = 3; d_tail[1] = 1; d_data[1] = 48'hDEAD;
    d_ordy = '1;
    settle();
    checks++;
    if (bus.in_ready !== 3'b010) begin
      errors++; $display("FAIL illegal_rdy: got %b exp 010", bus.in_ready);
    end
    advance();
    checks++;
    if (bus.out_valid !== 3'b000 || bus.dest_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_out: got %b/%b exp 000/1", bus.out_valid, bus.dest_err);
    end
    clear_inputs();
    d_ordy = '1;
    settle();
    advance();
    checks++;
    if (bus.dest_err !== 1'b1) begin
      errors++; $display("FAIL illegal_sticky: got %b exp 1", bus.dest_err);
    end
  endtask

  task automatic test_lock();
    int sent;
    int exp_seq [4];
`ifdef XBAR_PKT_LOCK_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    do_reset();
    clear_inputs();
    d_ordy = '1;
    d_valid[1] = 1; d_dest[1] = 0; d_tail[1] = 1; d_data[1] = 48'h1111;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      d_valid[0] = (sent < 3);
      d_dest[0] = 0;
      d_tail[0] = (sent == 2);
      d_data[0] = 48'h2000 + 48'(sent);
      settle();
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL lock_rdy[%0d]: got %b exp %b", c, bus.in_ready, exp_rdy);
      end
      if (exp_rdy[0]) sent++;
      advance();
      checks++;
      if (bus.out_src[0 +: SW] !== SW'(exp_seq[c])) begin
        errors++;
        $display("FAIL lock_src[%0d]: got %0d exp %0d", c, bus.out_src[0 +: SW], exp_seq[c]);
      end
    end
    clear_inputs();
    d_ordy = '1;
    settle();
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        d_valid[i] = ($urandom_range(0, 3) != 0);
        d_dest[i] = ($urandom_range(0, 9) == 0) ? 2'd3 : DW'($urandom_range(0, 2));
        d_tail[i] = ($urandom_range(0, 2) == 0);
        d_data[i] = {$urandom, $urandom};
      end
      for (int o = 0; o < NO; o++) d_ordy[o] = ($urandom_range(0, 3) != 0);
      settle();
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_rdy[%0d]: got %b exp %b", c, bus.in_ready, exp_rdy);
      end
      advance();
      for (int o = 0; o < NO; o++) begin
        checks++;
        if (bus.out_valid[o] !== m_vld[o]) begin
          errors++;
          $display("FAIL rnd_valid[%0d][%0d]: got %b exp %b", c, o, bus.out_valid[o], m_vld[o]);
        end else if (m_vld[o]) begin
          checks++;
          if (bus.out_data[o*W +: W] !== m_data[o] ||
              bus.out_tail[o] !== m_tail[o] ||
              bus.out_src[o*SW +: SW] !== SW'(m_src[o])) begin
            errors++;
            $display("FAIL rnd_out[%0d][%0d]: got %h/%b/%0d exp %h/%b/%0d", c, o,
                     bus.out_data[o*W +: W], bus.out_tail[o], bus.out_src[o*SW +: SW],
                     m_data[o], m_tail[o], m_src[o]);
          end
        end
      end
      checks++;
      if (bus.dest_err !== m_err) begin
        errors++; $display("FAIL rnd_err[%0d]: got %b exp %b", c, bus.dest_err, m_err);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    clear_inputs();
    d_valid[0] = 1; d_dest[0] = 0; d_tail[0] = 0; d_data[0] = 48'h5A5A;
    d_ordy = '1;
    settle();
    advance();
    checks++;
    if (bus.out_valid[0] !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got %b exp 1", bus.out_valid[0]);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 3'b000 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL areset_out: got %b/%h exp 0/0", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.out_src !== '0 || bus.out_tail !== '0 || bus.dest_err !== 1'b0) begin
      errors++;
      $display("FAIL areset_meta: got %h/%b/%b exp 0", bus.out_src, bus.out_tail, bus.dest_err);
    end
    model_reset();
    clear_inputs();
    apply();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      d_valid[i] = 1; d_dest[i] = 0; d_tail[i] = 1; d_data[i] = 48'h300 + 48'(i);
    end
    d_ordy = '1;
    settle();
    checks++;
    if (bus.in_ready !== 3'b001) begin
      errors++; $display("FAIL areset_rdy: got %b exp 001", bus.in_ready);
    end
    advance();
    checks++;
    if (bus.out_src[0 +: SW] !== 2'd0 || bus.out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL areset_src: got %0d/%b exp 0/1", bus.out_src[0 +: SW], bus.out_valid[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_lock();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xbar_rr.md
# xbar_rr

Parametrised, registered N_IN×N_OUT router crossbar with per-output round-robin arbitration and valid/ready flow control on every port. It replaces fixed-width, statically steered mux crossbars between input buffers and link/PE outports. Each output owns a one-entry output register and resolves contention among the inputs locally, so no external routing controller is needed.

## Interface
- N_IN, 3, number of input channels
- N_OUT, 3, number of output channels
- WIDTH, 48, flit payload width
- clk  in  1  clock, rising edge
- reset  in  1  reset; asynchronous assert, active-low
- in_valid  in  N_IN  flit present on input i
- in_ready  out  N_IN  input i flit consumed this cycle
- in_data  in  N_IN*WIDTH  payloads; input i at [i*WIDTH +: WIDTH]
- in_dest  in  N_IN*DEST_W  destination output index, DEST_W = max(1,clog2(N_OUT))
- in_tail  in  N_IN  last flit of packet
- out_valid  out  N_OUT  output register o holds a flit
- out_ready  in  N_OUT  downstream accepts output o
- out_data  out  N_OUT*WIDTH  registered payload
- out_tail  out  N_OUT  registered tail flag
- out_src  out  N_OUT*SRC_W  winning input index, SRC_W = max(1,clog2(N_IN))
- dest_err  out  1  sticky: a flit with in_dest >= N_OUT was dropped

## Operation
- Input i requests output o when in_valid[i] and in_dest[i]==o. Each input requests at most one output, so grants never conflict.
- Output slot o is open when !out_valid[o] or out_ready[o] is high in the same cycle.
- If slot o is open and has requests, the round-robin arbiter grants the first requester at or after ptr[o], wrapping modulo N_IN.
  - in_ready[g] is combinational.
  - On the edge, the slot loads data, tail and src=g, and ptr[o] <= (g+1) mod N_IN.
- If out_ready[o] is high and nothing is granted, out_valid[o] clears. If a grant coincides with a drain, the slot reloads with no bubble.
- A flit with in_dest >= N_OUT is illegal. It is consumed the same cycle (in_ready=1, no output loaded) and dest_err sets until reset.
- Flits without a request never see in_ready asserted. There is no internal input buffering.

## Timing
- Latency: a flit accepted at edge k has out_valid high after edge k, so it is visible in cycle k+1.
- Throughput: 1 flit/cycle/output under continuous out_ready.
- out_* are register outputs. in_ready depends combinationally on in_valid, in_dest, out_ready and state.
- Reset (any time, including mid-packet): out_valid=0, out_data=0, out_tail=0, out_src=0, ptr=0, locks cleared, dest_err=0. Flits in flight are lost.
- ptr wrap: a grant to input N_IN-1 sets ptr to 0.
- Stall: while out_valid[o] && !out_ready[o], out_data, out_tail and out_src hold, and all requesters to o see in_ready=0.

## Configuration
- XBAR_PKT_LOCK_EN defined:
  - When output o grants a non-tail flit from input g, it locks to g.
  - While locked, only input g may win o, even if other inputs are requesting; ptr[o] does not advance.
  - Accepting g's tail flit releases the lock and sets ptr[o] = (g+1) mod N_IN.
  - A single-flit packet (tail on head) never locks.
- XBAR_PKT_LOCK_EN undefined: every flit is arbitrated independently, and in_tail is only passed through to out_tail.

## Structure
- Shared header/package xbar_pkg holds:
  - the DEST_W/SRC_W derivation function (clog2 with minimum of 1)
  - default WIDTH=48, N_IN=3, N_OUT=3
- Sub-module rr_arbiter (parameter N; ports req, ptr, grant one-hot, grant_idx, any). It is instantiated N_OUT times.
- Per-output lock state lives in xbar_rr.

## Test plan
- Reset then single flit: in0 data=0xAAAA dest=2 tail=1, out_ready=1 -> in_ready[0]=1 at cycle 0; out_valid[2]=1, out_data=0xAAAA, out_src=0 at cycle 1; other outputs stay 0.
- Contention: in0, in1 and in2 all dest=1 for 6 cycles, out_ready=1 -> grant order 0,1,2,0,1,2; exactly one in_ready per cycle.
- Backpressure: out_ready[0]=0 for 4 cycles with a flit held -> out_data stable and in_ready to dest 0 stays 0; on release, the next flit follows with no bubble.
- Illegal dest: N_OUT=3 with in1 dest=3 -> in_ready[1]=1, no out_valid, dest_err=1 until reset.
- With XBAR_PKT_LOCK_EN: in0 sends a 3-flit packet to out0 while in1 also requests out0 -> out0 shows src 0,0,0 then src 1. Without the macro: src order 0,1,0,1.
- Async reset asserted mid-packet with out_valid high -> all outputs 0 immediately. After release, arbitration restarts at ptr=0.
